// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin conversion scan of an 8-channel serial SAR ADC, one result strobe per enabled channel.
// Latency: start to first res_valid = 1 + 2*(CONV_CYCLES + RES_W*2*CLK_DIV) clk, because the first frame only programs the ADC.
// Backpressure: none; res_valid and scan_done are single-cycle strobes the consumer must take when offered.
// Build option ADC_AVG_EN: each channel is converted on 4 consecutive frames and reported as floor(sum/4).
module adc_scan_sequencer #(
  parameter int  CLK_DIV     = 4,
  parameter int  CONV_CYCLES = 80,
  parameter int  NUM_CH      = 8,
  parameter int  RES_W       = 12,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              adc_sclk,
  output logic              adc_cs_n,
  output logic              adc_din,
  input  logic              adc_dout,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [RES_W-1:0]  res_data,
  output logic              scan_done
);

  localparam int BIT_W = $clog2(RES_W);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;    // channel programmed by the current frame
  logic [CH_W-1:0]   prev_ch_q, prev_ch_d;  // channel whose result the current frame returns
  logic              first_q, first_d;      // current frame is the pipeline-priming dummy
  logic              last_q, last_d;        // current frame re-issues the last channel and ends the scan
  logic [15:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [RES_W-1:0]  sh_q, sh_d;
  logic [RES_W-1:0]  cfg_q, cfg_d;          // MSB is the adc_din pin
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   first_ch, nxt_ch;
  logic              nxt_found, launch, advance;
`ifdef ADC_AVG_EN
  logic [1:0]        rep_q, rep_d;
  logic [1:0]        acc_cnt_q, acc_cnt_d;
  logic [RES_W+1:0]  acc_q, acc_d, acc_sum;
`endif

  // ADC control word: single-ended, channel select, unipolar, no nap, padded with zeros
  function automatic logic [RES_W-1:0] cfg_word(input logic [2:0] ch);
    cfg_word = {1'b1, ch[0], ch[2:1], 1'b1, 1'b0, {(RES_W-6){1'b0}}};
  endfunction

  // Lowest enabled channel of the live mask (used when a scan is launched)
  always_comb begin
    first_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_enable[i]) first_ch = CH_W'(i);
    end
  end

  // Next enabled channel above the current one in the latched mask
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (CH_W'(i) > cur_ch_q)) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // Next-state and output decode for the scan FSM
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cur_ch_d    = cur_ch_q;
    prev_ch_d   = prev_ch_q;
    first_d     = first_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sh_d        = sh_q;
    cfg_d       = cfg_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
    launch      = 1'b0;
    advance     = 1'b1;
`ifdef ADC_AVG_EN
    rep_d       = rep_q;
    acc_cnt_d   = acc_cnt_q;
    acc_d       = acc_q;
    acc_sum     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && (|ch_enable)) launch = 1'b1;
      end

      S_CONV: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CONV_CYCLES - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          cfg_d   = cfg_word(3'(cur_ch_q));
        end
      end

      S_SHIFT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          // rising sclk: capture the ADC bit
          sclk_d = 1'b1;
          sh_d   = {sh_q[RES_W-2:0], adc_dout};
        end
        if (cnt_q == 16'(2 * CLK_DIV - 1)) begin
          sclk_d = 1'b0;
          cnt_d  = '0;
          if (bit_q == BIT_W'(RES_W - 1)) begin
            cs_n_d    = 1'b1;
            cfg_d     = '0;
            bit_d     = '0;
            first_d   = 1'b0;
            prev_ch_d = cur_ch_q;
            if (!first_q) begin
`ifdef ADC_AVG_EN
              acc_sum   = acc_q + {2'b00, sh_q};
              acc_cnt_d = acc_cnt_q + 2'd1;
              if (acc_cnt_q == 2'd3) begin
                res_valid_d = 1'b1;
                res_ch_d    = prev_ch_q;
                res_data_d  = acc_sum[RES_W+1:2];
                acc_d       = '0;
              end else begin
                acc_d = acc_sum;
              end
`else
              res_valid_d = 1'b1;
              res_ch_d    = prev_ch_q;
              res_data_d  = sh_q;
`endif
            end
            if (last_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_CONV;
`ifdef ADC_AVG_EN
              rep_d   = rep_q + 2'd1;
              advance = (rep_q == 2'd3);
`endif
              if (advance) begin
                if (nxt_found) cur_ch_d = nxt_ch;
                else           last_d   = 1'b1;
              end
            end
          end else begin
            // falling sclk: present the next config bit
            bit_d = bit_q + BIT_W'(1);
            cfg_d = {cfg_q[RES_W-2:0], 1'b0};
          end
        end
      end

      S_DONE: begin
        done_d = 1'b1;
        if (continuous && (|ch_enable)) begin
          launch = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Scan launch: latch the mask and prime the pipeline with a dummy frame
    if (launch) begin
      state_d  = S_CONV;
      mask_d   = ch_enable;
      cur_ch_d = first_ch;
      first_d  = 1'b1;
      last_d   = 1'b0;
      cnt_d    = '0;
      busy_d   = 1'b1;
`ifdef ADC_AVG_EN
      rep_d     = '0;
      acc_cnt_d = '0;
      acc_d     = '0;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      cur_ch_q    <= '0;
      prev_ch_q   <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      cfg_q       <= '0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef ADC_AVG_EN
      rep_q       <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cur_ch_q    <= cur_ch_d;
      prev_ch_q   <= prev_ch_d;
      first_q     <= first_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      cfg_q       <= cfg_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
`ifdef ADC_AVG_EN
      rep_q       <= rep_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign adc_sclk  = sclk_q;
  assign adc_cs_n  = cs_n_q;
  assign adc_din   = cfg_q[RES_W-1];
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed checks of scan order, ADC frame format, timing and reset.
// An ADC model returns queued samples frame by frame; a monitor logs config words and results.
module tb_adc_scan_sequencer;

  logic        clk;
  logic        reset;
  logic [7:0]  ch_enable;
  logic        start;
  logic        continuous;
  logic        busy;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_din;
  logic        adc_dout;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        scan_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] adc_vals[$];   // sample returned by each successive frame
  logic [11:0] din_log[$];    // 12-bit word clocked out on adc_din per frame
  logic [2:0]  rch_log[$];
  logic [11:0] rdat_log[$];

  adc_scan_sequencer #(
    .CLK_DIV    (4),
    .CONV_CYCLES(80),
    .NUM_CH     (8),
    .RES_W      (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_enable (ch_enable),
    .start     (start),
    .continuous(continuous),
    .busy      (busy),
    .adc_sclk  (adc_sclk),
    .adc_cs_n  (adc_cs_n),
    .adc_din   (adc_din),
    .adc_dout  (adc_dout),
    .res_valid (res_valid),
    .res_ch    (res_ch),
    .res_data  (res_data),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC model and bus monitor, evaluated on the falling clk edge
  initial begin : adc_model
    logic        prev_cs_n;
    logic        prev_sclk;
    logic [11:0] cur_val;
    logic [11:0] cap;
    int          bidx;
    prev_cs_n = 1'b1;
    prev_sclk = 1'b0;
    cur_val   = '0;
    cap       = '0;
    bidx      = 0;
    adc_dout  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_cs_n && !adc_cs_n) begin
        cur_val  = (adc_vals.size() > 0) ? adc_vals.pop_front() : 12'h000;
        bidx     = 0;
        adc_dout = cur_val[11];
        cap      = '0;
      end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
        bidx++;
        if (bidx < 12) adc_dout = cur_val[11-bidx];
      end
      if (!adc_cs_n && adc_sclk && !prev_sclk) cap = {cap[10:0], adc_din};
      if (!prev_cs_n && adc_cs_n) din_log.push_back(cap);
      if (res_valid) begin
        rch_log.push_back(res_ch);
        rdat_log.push_back(res_data);
      end
      prev_cs_n = adc_cs_n;
      prev_sclk = adc_sclk;
    end
  end

  task automatic clear_logs();
    adc_vals.delete();
    din_log.delete();
    rch_log.delete();
    rdat_log.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_scan_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (scan_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit hit;
    start      = 1'b0;
    continuous = 1'b0;
    ch_enable  = 8'h00;
    reset      = 1'b0;
    #2 reset   = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, adc_sclk, adc_cs_n, adc_din, res_valid, scan_done, res_ch, res_data} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_state: observed %b_%b_%b_%b_%b_%b_%h_%h required 0_0_1_0_0_0_0_000",
               busy, adc_sclk, adc_cs_n, adc_din, res_valid, scan_done, res_ch, res_data);
    end
    reset = 1'b0;
    @(negedge clk);
    // abort a frame in mid-shift
    clear_logs();
    ch_enable = 8'h05;
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!adc_cs_n) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ({hit, adc_cs_n} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_reach_shift: observed hit=%b cs_n=%b required hit=1 cs_n=0", hit, adc_cs_n);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({adc_cs_n, adc_sclk, busy, res_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_midframe: observed cs_n/sclk/busy/res_valid=%b required 1000",
               {adc_cs_n, adc_sclk, busy, res_valid});
    end
    reset = 1'b0;
    repeat (800) @(negedge clk);
    n_checks++;
    if ({rdat_log.size(), busy} !== {32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_no_result: observed results=%0d busy=%b required 0 and 0", rdat_log.size(), busy);
    end
    ch_enable = 8'h00;
  endtask

  task automatic test_scan_two_channels();
    bit ok;
    clear_logs();
    adc_vals.push_back(12'hFFF);  // dummy frame sample, must not be reported
    adc_vals.push_back(12'hA5A);
    adc_vals.push_back(12'h123);
    ch_enable = 8'h05;
    pulse_start();
    repeat (5) @(negedge clk);
    ch_enable = 8'hFF;            // mid-scan change must be ignored
    wait_scan_done(2000, ok);
    n_checks++;
    if ({ok, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL scan2_done: observed done=%b busy=%b required 1 and 0", ok, busy);
    end
    n_checks++;
    if (rdat_log.size() !== 2) begin
      n_fail++;
      $display("FAIL scan2_result_count: observed %0d required 2", rdat_log.size());
    end
    if (rdat_log.size() >= 2) begin
      n_checks++;
      if ({rch_log[0], rdat_log[0]} !== {3'd0, 12'hA5A}) begin
        n_fail++;
        $display("FAIL scan2_res0: observed ch%0d %h required ch0 a5a", rch_log[0], rdat_log[0]);
      end
      n_checks++;
      if ({rch_log[1], rdat_log[1]} !== {3'd2, 12'h123}) begin
        n_fail++;
        $display("FAIL scan2_res1: observed ch%0d %h required ch2 123", rch_log[1], rdat_log[1]);
      end
    end
    n_checks++;
    if (din_log.size() !== 3) begin
      n_fail++;
      $display("FAIL scan2_frames: observed %0d required 3", din_log.size());
    end
    if (din_log.size() >= 3) begin
      // ch0 -> 1,0,00,1,0 = 100010 ; ch2 (3'b010) -> 1,0,01,1,0 = 100110 ; six zero pad bits
      n_checks++;
      if (din_log[0] !== 12'b100010_000000) begin
        n_fail++;
        $display("FAIL scan2_din0: observed %b required 100010000000", din_log[0]);
      end
      n_checks++;
      if (din_log[1] !== 12'b100110_000000) begin
        n_fail++;
        $display("FAIL scan2_din1: observed %b required 100110000000", din_log[1]);
      end
      n_checks++;
      if (din_log[2] !== 12'b100110_000000) begin
        n_fail++;
        $display("FAIL scan2_din2: observed %b required 100110000000", din_log[2]);
      end
    end
    ch_enable = 8'h00;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_continuous();
    bit ok1, ok2, ok3;
    logic [11:0] exp_dat [3];
    exp_dat[0] = 12'h111;
    exp_dat[1] = 12'h222;
    exp_dat[2] = 12'h333;
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      adc_vals.push_back(12'h000);
      adc_vals.push_back(exp_dat[k]);
    end
    ch_enable  = 8'h80;
    continuous = 1'b1;
    pulse_start();
    wait_scan_done(1000, ok1);
    wait_scan_done(1000, ok2);
    continuous = 1'b0;
    wait_scan_done(1000, ok3);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ok1, ok2, ok3, busy, adc_cs_n} !== 5'b11101) begin
      n_fail++;
      $display("FAIL cont_stop: observed done=%b%b%b busy=%b cs_n=%b required 111 0 1",
               ok1, ok2, ok3, busy, adc_cs_n);
    end
    repeat (400) @(negedge clk);
    n_checks++;
    if (rdat_log.size() !== 3) begin
      n_fail++;
      $display("FAIL cont_result_count: observed %0d required 3", rdat_log.size());
    end
    if (rdat_log.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if ({rch_log[k], rdat_log[k]} !== {3'd7, exp_dat[k]}) begin
          n_fail++;
          $display("FAIL cont_res%0d: observed ch%0d %h required ch7 %h", k, rch_log[k], rdat_log[k], exp_dat[k]);
        end
      end
    end
    if (din_log.size() >= 1) begin
      // ch7 -> 1,1,11,1,0
      n_checks++;
      if (din_log[0] !== 12'b111110_000000) begin
        n_fail++;
        $display("FAIL cont_din: observed %b required 111110000000", din_log[0]);
      end
    end
    ch_enable = 8'h00;
  endtask

  task automatic test_ignored_start();
    bit ok;
    bit moved;
    clear_logs();
    ch_enable = 8'h00;
    pulse_start();
    moved = 1'b0;
    repeat (30) begin
      if (busy || !adc_cs_n) moved = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (moved !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_mask_start: observed activity=%b required 0", moved);
    end
    adc_vals.push_back(12'h000);
    adc_vals.push_back(12'h777);
    ch_enable = 8'h01;
    pulse_start();
    repeat (10) @(negedge clk);
    ch_enable = 8'h02;
    pulse_start();                // busy: must not queue a second scan
    wait_scan_done(2000, ok);
    repeat (500) @(negedge clk);
    n_checks++;
    if ({ok, busy, din_log.size(), rdat_log.size()} !== {1'b1, 1'b0, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL busy_start_ignored: observed done=%b busy=%b frames=%0d results=%0d required 1 0 2 1",
               ok, busy, din_log.size(), rdat_log.size());
    end
    if (rdat_log.size() >= 1) begin
      n_checks++;
      if ({rch_log[0], rdat_log[0]} !== {3'd0, 12'h777}) begin
        n_fail++;
        $display("FAIL single_ch_result: observed ch%0d %h required ch0 777", rch_log[0], rdat_log[0]);
      end
    end
    ch_enable = 8'h00;
  endtask

  task automatic test_timing();
    int cyc, first_low, hi_run, sclk_hi, rise1, rise2;
    logic prev_s;
    bit ok;
    clear_logs();
    adc_vals.push_back(12'h000);
    adc_vals.push_back(12'h456);
    ch_enable = 8'h01;
    first_low = 0;
    hi_run    = 0;
    sclk_hi   = 0;
    rise1     = 0;
    rise2     = 0;
    prev_s    = 1'b0;
    pulse_start();
    cyc = 1;
    while (cyc < 2000) begin
      if (res_valid) break;
      if (!adc_cs_n && first_low == 0) first_low = cyc;
      if (first_low != 0 && adc_cs_n) hi_run++;
      if (adc_sclk) sclk_hi++;
      if (adc_sclk && !prev_s) begin
        if (rise1 == 0)      rise1 = cyc;
        else if (rise2 == 0) rise2 = cyc;
      end
      prev_s = adc_sclk;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 353) begin
      n_fail++;
      $display("FAIL timing_first_result: observed clk %0d required 353", cyc);
    end
    n_checks++;
    if (first_low !== 81) begin
      n_fail++;
      $display("FAIL timing_first_conv: observed cs_n low at clk %0d required 81", first_low);
    end
    n_checks++;
    if (hi_run !== 80) begin
      n_fail++;
      $display("FAIL timing_conv_gap: observed %0d clks required 80", hi_run);
    end
    n_checks++;
    if ({rise2 - rise1, sclk_hi} !== {32'd8, 32'd96}) begin
      n_fail++;
      $display("FAIL timing_sclk: observed period %0d high %0d required 8 and 96", rise2 - rise1, sclk_hi);
    end
    n_checks++;
    if ({res_ch, res_data} !== {3'd0, 12'h456}) begin
      n_fail++;
      $display("FAIL timing_result: observed ch%0d %h required ch0 456", res_ch, res_data);
    end
    wait_scan_done(1000, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL timing_done: observed %b required 1", ok);
    end
    ch_enable = 8'h00;
    repeat (5) @(negedge clk);
  endtask

`ifdef ADC_AVG_EN
  task automatic test_avg();
    bit ok;
    clear_logs();
    adc_vals.push_back(12'h000);
    adc_vals.push_back(12'd100);
    adc_vals.push_back(12'd101);
    adc_vals.push_back(12'd102);
    adc_vals.push_back(12'd104);
    ch_enable = 8'h02;
    pulse_start();
    wait_scan_done(3000, ok);
    repeat (5) @(negedge clk);
    // (100+101+102+104)=407, floor(407/4)=101 ; 4 issues of ch1 plus the closing re-issue = 5 frames
    n_checks++;
    if ({ok, din_log.size(), rdat_log.size()} !== {1'b1, 32'd5, 32'd1}) begin
      n_fail++;
      $display("FAIL avg_shape: observed done=%b frames=%0d results=%0d required 1 5 1",
               ok, din_log.size(), rdat_log.size());
    end
    if (rdat_log.size() >= 1) begin
      n_checks++;
      if ({rch_log[0], rdat_log[0]} !== {3'd1, 12'd101}) begin
        n_fail++;
        $display("FAIL avg_result: observed ch%0d %0d required ch1 101", rch_log[0], rdat_log[0]);
      end
    end
    ch_enable = 8'h00;
  endtask
`endif

  initial begin
    start      = 1'b0;
    continuous = 1'b0;
    ch_enable  = 8'h00;
    reset      = 1'b0;
    test_reset();
    test_scan_two_channels();
    test_continuous();
    test_ignored_start();
    test_timing();
`ifdef ADC_AVG_EN
    test_avg();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
